// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and defaults for the chunked serial adder: FSM encoding,
// default geometry and the chunk-index width helper.
package chunked_serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Chunk index width: clog2 of the chunk count, never narrower than one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunked_serial_adder_ripple.sv
// chunk_ripple_adder: combinational CHUNK-bit ripple slice made of full-adder cells.
module chunk_ripple_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle unsigned adder: WIDTH-bit operands summed CHUNK bits per clock with a
// registered carry. Define ADDER_SUB_EN to add the sub port (A - B via inverted B).
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] add1,
    input  logic [WIDTH-1:0] add2,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int            NCHUNK   = WIDTH / CHUNK;
    localparam int            IW       = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, psum, psum_next;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic             sub_sel;

`ifdef ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    chunk_ripple_adder #(.CHUNK(CHUNK)) u_slice (
        .a  (a_sh[CHUNK-1:0]),
        .b  (b_sh[CHUNK-1:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // Each new chunk enters the partial sum from the top, so after NCHUNK
    // shifts the least significant chunk has arrived at bit 0.
    if (NCHUNK > 1) begin : g_multi
        assign psum_next = {slice_s, psum[WIDTH-1:CHUNK]};
    end else begin : g_single
        assign psum_next = slice_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next takes its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (in_valid)        state_next = S_RUN;
            S_RUN:   if (idx == LAST_IDX) state_next = S_DONE;
            S_DONE:  if (out_ready)       state_next = S_IDLE;
            default:                      state_next = S_IDLE;
        endcase
    end

    // NOTE: the datapath is reset as well, so an aborted operation leaves sum at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (in_valid) begin
                    a_sh  <= add1;
                    b_sh  <= sub_sel ? ~add2 : add2;
                    carry <= sub_sel | cin;
                    idx   <= '0;
                end
                S_RUN: begin
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    psum  <= psum_next;
                    carry <= slice_co;
                    idx   <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        sum  <= psum_next;
                        cout <= slice_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder: a 16/4 instance with directed and
// random operations, and an 8/8 instance (single RUN cycle) with random operations.
module tb_chunked_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [15:0] add1, add2, sum;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
    logic [7:0]  add1_8, add2_8, sum8;
`ifdef ADDER_SUB_EN
    logic        sub, sub8;
`endif

    logic        rs;
    int          n_checks = 0;
    int          n_fail   = 0;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .add1      (add1),
        .add2      (add2),
        .cin       (cin),
`ifdef ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .add1      (add1_8),
        .add2      (add2_8),
        .cin       (cin8),
`ifdef ADDER_SUB_EN
        .sub       (sub8),
`endif
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .busy      (busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 16-bit operation: accept, measure latency, check result, optionally stall
    // in DONE for 'hold' cycles (with in_valid noise if requested), then take it.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s, input int hold, input logic noise);
        logic [16:0] exp;
        int          lat;
        if (s) exp = {(a >= b), 16'(a - b)};
        else   exp = {1'b0, a} + {1'b0, b} + {16'b0, c};
        add1 = a; add2 = b; cin = c; in_valid = 1'b1;
`ifdef ADDER_SUB_EN
        sub = s;
`endif
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = noise;
        add1 = 16'($urandom); add2 = 16'($urandom); cin = 1'($urandom_range(1));
        check("busy_run", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency16", lat, 32'd4);
        check("sum16", {16'b0, sum}, {16'b0, exp[15:0]});
        check("cout16", {31'b0, cout}, {31'b0, exp[16]});
        for (int i = 0; i < hold; i++) begin
            add1 = 16'($urandom); add2 = 16'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_sum", {15'b0, cout, sum}, {15'b0, exp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("take_in_ready", {31'b0, in_ready}, 32'd1);
        check("take_idle", {30'b0, out_valid, busy}, 32'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic s);
        logic [8:0] exp;
        int         lat;
        if (s) exp = {(a >= b), 8'(a - b)};
        else   exp = {1'b0, a} + {1'b0, b} + {8'b0, c};
        add1_8 = a; add2_8 = b; cin8 = c; in_valid8 = 1'b1;
`ifdef ADDER_SUB_EN
        sub8 = s;
`endif
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        add1_8 = 8'($urandom); add2_8 = 8'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency8", lat, 32'd1);
        check("result8", {23'b0, cout8, sum8}, {23'b0, exp});
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("take8_in_ready", {31'b0, in_ready8}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; add1 = '0; add2 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; cin8 = 1'b0; add1_8 = '0; add2_8 = '0;
`ifdef ADDER_SUB_EN
        sub = 1'b0; sub8 = 1'b0;
`endif
        rs = 1'b0;
        #2;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_valid_busy", {30'b0, out_valid, busy}, 32'd0);
        check("rst_sum", {15'b0, cout, sum}, 32'd0);
        check("rst8", {20'b0, in_ready8, out_valid8, busy8, cout8, sum8}, 32'h800);
        #20 rst = 1'b0;

        // Directed arithmetic, carry chain and carry-in cases.
        op16(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        op16(16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        // Backpressure for 10 cycles with in_valid pulses in RUN and DONE.
        op16(16'hA5A5, 16'h1C3E, 1'b1, 1'b0, 10, 1'b1);
`ifdef ADDER_SUB_EN
        op16(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
        op16(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
`endif

        for (int n = 0; n < 20; n++) begin
`ifdef ADDER_SUB_EN
            rs = 1'($urandom_range(1));
`endif
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(1)), rs,
                 $urandom_range(3), 1'($urandom_range(1)));
        end

        // Abort after two RUN cycles: previous nonzero result must clear.
        op16(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        add1 = 16'h00AA; add2 = 16'h0055; cin = 1'b0; in_valid = 1'b1;
`ifdef ADDER_SUB_EN
        sub = 1'b0;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("abort_valid_busy", {30'b0, out_valid, busy}, 32'd0);
        check("abort_sum", {15'b0, cout, sum}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        op16(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

        // Single-chunk geometry against the same reference model.
        for (int n = 0; n < 30; n++) begin
`ifdef ADDER_SUB_EN
            rs = 1'($urandom_range(1));
`endif
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(1)), rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
